onehot_count_accum: RTL

- Downstream consumer of the 4-input ones-counter stage.
- Takes its 5-bit one-hot count per sample: bit0 = 0 ones, bit1 = 1, bit2 = 2, bit3 = 3, bit4 = 4.
- Decodes each sample to binary and accumulates a running total over a fixed window of WINDOW samples.
- Presents the window sum and an error flag on a valid/ready output, which feeds the tile's output pins/logger.

---
 rtl/onehot_accum_pkg.sv | 17 +
 rtl/onehot_decode.sv | 35 +++
 rtl/onehot_count_accum.sv | 102 ++++++++++
 3 files changed

// File: rtl/onehot_accum_pkg.sv
// Shared types and constants for the one-hot count accumulator.
package onehot_accum_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam int OH_W  = 5;
  localparam int DEC_W = 3;

  // The sum must hold WINDOW samples of value 4 without wrapping, and the
  // sample counter must reach WINDOW-1.
  function automatic bit params_legal(input int window, input int sum_w, input int cnt_w);
    if (window < 2 || window > 255) return 1'b0;
    if (sum_w < DEC_W || sum_w > 30 || cnt_w < 1 || cnt_w > 30) return 1'b0;
    return ((1 << sum_w) > 4 * window) && ((1 << cnt_w) > window);
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// One-hot ones-count decoder. With ONEHOT_STRICT_CHECK_EN defined, any input
// that is not exactly one-hot is flagged bad and decodes to 0.
module onehot_decode
  import onehot_accum_pkg::*;
(
  input  logic [OH_W-1:0]  in_onehot,
  output logic [DEC_W-1:0] dec,
  output logic             bad
);

`ifdef ONEHOT_STRICT_CHECK_EN
  logic [DEC_W-1:0] ones;

  always_comb begin
    dec  = '0;
    ones = '0;
    for (int i = 0; i < OH_W; i++) begin
      ones = ones + {{(DEC_W-1){1'b0}}, in_onehot[i]};
      if (in_onehot[i]) dec = DEC_W'(i);
    end
    bad = (ones != DEC_W'(1));
    if (bad) dec = '0;
  end
`else
  // Highest set bit wins; an all-zero input decodes to 0.
  always_comb begin
    dec = '0;
    for (int i = 0; i < OH_W; i++)
      if (in_onehot[i]) dec = DEC_W'(i);
  end

  assign bad = 1'b0;
`endif

endmodule

// File: rtl/onehot_count_accum.sv
// Window accumulator of decoded one-hot counts with a valid/ready result port.
// Optional strict one-hot checking via ONEHOT_STRICT_CHECK_EN.
module onehot_count_accum
  import onehot_accum_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int SUM_W  = 7,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OH_W-1:0]  in_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_err
);

  if (!params_legal(WINDOW, SUM_W, CNT_W)) begin : g_bad_params
    $error("onehot_count_accum: illegal WINDOW/SUM_W/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_e           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [DEC_W-1:0] dec;
  logic             bad;
  logic [SUM_W-1:0] dec_w;
  logic             in_xfer;
  logic             out_xfer;
  logic             last;

  onehot_decode u_dec (
    .in_onehot (in_onehot),
    .dec       (dec),
    .bad       (bad)
  );

  // A rejected sample contributes nothing to the sum.
  assign dec_w    = bad ? '0 : SUM_W'(dec);
  assign in_ready = (state == ACCUM) || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last     = (state == ACCUM) && (cnt == LAST);

  // acc/cnt are already zero in HOLD, so a sample taken alongside the
  // output transfer naturally becomes sample 1 of the next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
        state     <= ACCUM;
      end
      if (in_xfer) begin
        if (last) begin
          out_sum   <= acc + dec_w;
          out_valid <= 1'b1;
          state     <= HOLD;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc + dec_w;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ONEHOT_STRICT_CHECK_EN
  logic err;
  logic out_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      out_err_q <= 1'b0;
    end else if (in_xfer) begin
      if (last) begin
        out_err_q <= err | bad;
        err       <= 1'b0;
      end else begin
        err <= err | bad;
      end
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
